// File: rtl/crypto_dispatch_if.sv
// crypto_dispatch_if: CPU request/done pulses, engine start/fin handshakes
// and status flags of the crypto dispatch stage, bundled as one bus.
interface crypto_dispatch_if #(
  parameter int IDX_W = 11
);
  logic             H_int, E_int, D_int;
  logic [IDX_W-1:0] index;
  logic             H_done, E_done, D_done;
  logic             h_start, e_start, d_start;
  logic [IDX_W-1:0] eng_index;
  logic             h_fin, e_fin, d_fin;
  logic             busy, fifo_full, err_drop, err_timeout;

  // the dispatch block
  modport slave (
    input  H_int, E_int, D_int, index, h_fin, e_fin, d_fin,
    output H_done, E_done, D_done, h_start, e_start, d_start, eng_index,
           busy, fifo_full, err_drop, err_timeout
  );

  // the CPU and engines around it
  modport master (
    output H_int, E_int, D_int, index, h_fin, e_fin, d_fin,
    input  H_done, E_done, D_done, h_start, e_start, d_start, eng_index,
           busy, fifo_full, err_drop, err_timeout
  );
endinterface

// File: rtl/crypto_dispatch.sv
// crypto_dispatch: queues CPU hash/encrypt/decrypt requests and hands them
// one at a time to the H/E/D engines, returning a done pulse per request.
// Optional feature: CRYPTO_DISPATCH_TIMEOUT_EN adds a WAIT timeout counter
// and the sticky err_timeout flag; without it WAIT only exits on fin.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no request active; pops the FIFO head when one is queued
// S_ISSUE | start pulse to the active engine
// S_WAIT  | waiting for the active engine's fin (or timeout)
// S_DONE  | done pulse to the CPU for the active request type
module crypto_dispatch #(
  parameter int DEPTH   = 4,
  parameter int IDX_W   = 11,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  crypto_dispatch_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = IDX_W + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] T_H = 2'd0;
  localparam logic [1:0] T_E = 2'd1;
  localparam logic [1:0] T_D = 2'd2;

  state_t           state_q, state_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [1:0]       type_q;
  logic [IDX_W-1:0] eng_index_q;
  logic             err_drop_q;

  logic             fifo_empty, fifo_full;
  logic             req_any, req_multi, push, pop, drop;
  logic [1:0]       push_type;
  logic             act_fin, tmo_last;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(DEPTH));

  // Request capture: highest priority wins, extras and overflow are dropped.
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  always_comb begin
    req_any   = bus.H_int | bus.E_int | bus.D_int;
    req_multi = (bus.H_int & bus.E_int) | (bus.H_int & bus.D_int) |
                (bus.E_int & bus.D_int);
    push_type = T_D;
    if (bus.H_int)      push_type = T_H;
    else if (bus.E_int) push_type = T_E;
    pop  = (state_q == S_IDLE) && !fifo_empty;
    push = req_any && (!fifo_full || pop);
    drop = req_multi || (req_any && fifo_full && !pop);
  end

  // FIFO storage; contents need no reset since count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_type, bus.index};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Only the active engine's fin is observed.
  always_comb begin
    act_fin = 1'b0;
    case (type_q)
      T_H:     act_fin = bus.h_fin;
      T_E:     act_fin = bus.e_fin;
      T_D:     act_fin = bus.d_fin;
      default: act_fin = 1'b0;
    endcase
  end

`ifdef CRYPTO_DISPATCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_timeout_q;

  // WAIT cycle counter: cleared while issuing, counts every WAIT cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE)     cnt_d = '0;
    else if (state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
  end

  assign tmo_last = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT - 1));

  // Counter register and sticky timeout flag (a fin on the last cycle wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (tmo_last && !act_fin) err_timeout_q <= 1'b1;
    end
  end

  assign bus.err_timeout = err_timeout_q;
`else
  assign tmo_last = 1'b0;
  // TIMEOUT has no effect in this build; the flag is permanently clear.
  assign bus.err_timeout = 1'b0 & (TIMEOUT < 2);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (act_fin || tmo_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Active request latch on pop, sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q      <= T_H;
      eng_index_q <= '0;
      err_drop_q  <= 1'b0;
    end else begin
      if (pop)  {type_q, eng_index_q} <= mem_q[rd_ptr_q];
      if (drop) err_drop_q <= 1'b1;
    end
  end

  assign bus.h_start   = (state_q == S_ISSUE) && (type_q == T_H);
  assign bus.e_start   = (state_q == S_ISSUE) && (type_q == T_E);
  assign bus.d_start   = (state_q == S_ISSUE) && (type_q == T_D);
  assign bus.H_done    = (state_q == S_DONE)  && (type_q == T_H);
  assign bus.E_done    = (state_q == S_DONE)  && (type_q == T_E);
  assign bus.D_done    = (state_q == S_DONE)  && (type_q == T_D);
  assign bus.eng_index = eng_index_q;
  assign bus.busy      = (state_q != S_IDLE) || !fifo_empty;
  assign bus.fifo_full = fifo_full;
  assign bus.err_drop  = err_drop_q;

endmodule

// File: tb/tb_crypto_dispatch.sv
// tb_crypto_dispatch: vector table, hand-written corner sequences and a
// randomized run checked against an in-order request model.
module tb_crypto_dispatch;
  localparam int DEPTH   = 4;
  localparam int IDX_W   = 11;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  crypto_dispatch_if #(.IDX_W(IDX_W)) bus ();

  crypto_dispatch #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]       typ;
    logic [IDX_W-1:0] idx;
  } req_t;

  typedef struct {
    logic [2:0]       mask;   // bit0 H, bit1 E, bit2 D
    logic [IDX_W-1:0] idx;
    int               delay;  // fin raised this many cycles after WAIT entry
    logic [1:0]       etype;
    int               start_off;
    int               done_off;
    logic             edrop;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  req_t exp_q[$];
  bit   model_drop = 0;

  int         start_cnt = 0, done_cnt = 0;
  int         last_start_cyc = 0, last_done_cyc = 0;
  logic [1:0] last_start_type = 0, last_done_type = 0;
  logic [IDX_W-1:0] last_start_idx = 0;
  int         exp_done_cyc = -1;

  int eng_mode = 0;   // 0 silent, 1 fin pulse after delay, 2 all fins held high
  int fix_delay = 0;
  bit rand_delay = 0;
  bit spur_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [1:0] enc(logic [2:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({bus.H_done, bus.E_done, bus.D_done, bus.h_start, bus.e_start,
                bus.d_start, bus.busy, bus.fifo_full, bus.err_drop,
                bus.err_timeout, bus.eng_index});
  endfunction

  // Observer: start order/index against the model, done type and timing.
  always @(negedge clk) begin
    logic [2:0] st, dn;
    req_t       e;
    st = {bus.d_start, bus.e_start, bus.h_start};
    dn = {bus.D_done, bus.E_done, bus.H_done};
    if (rst_n) begin
      if (st != 3'b000) begin
        chk("start_onehot", 64'($countones(st)), 1);
        start_cnt++;
        last_start_cyc  = cyc;
        last_start_type = enc(st);
        last_start_idx  = bus.eng_index;
        if (exp_q.size() == 0) chk("start_expected", 64'(exp_q.size()), 1);
        else begin
          e = exp_q.pop_front();
          chk("start_type", last_start_type, e.typ);
          chk("start_index", bus.eng_index, e.idx);
        end
      end
      if (dn != 3'b000) begin
        chk("done_onehot", 64'($countones(dn)), 1);
        done_cnt++;
        last_done_cyc  = cyc;
        last_done_type = enc(dn);
        chk("done_type", last_done_type, last_start_type);
        if (exp_done_cyc >= 0) chk("done_cycle", 64'(cyc), 64'(exp_done_cyc));
      end
    end
  end

  // Engine model: answers the active start, optionally toggles foreign fins.
  initial begin
    logic [2:0] f, st, s;
    logic [1:0] act;
    int         fin_at, d;
    act = 2'd0; fin_at = -1;
    bus.h_fin = 1'b0; bus.e_fin = 1'b0; bus.d_fin = 1'b0;
    forever begin
      @(negedge clk);
      f  = 3'b000;
      st = {bus.d_start, bus.e_start, bus.h_start};
      if (rst_n !== 1'b1) begin
        fin_at = -1;
        exp_done_cyc = -1;
      end else begin
        if (st != 3'b000) begin
          act = enc(st);
          if (eng_mode == 1) begin
            d = rand_delay ? int'($urandom_range(3, 0)) : fix_delay;
            fin_at = cyc + 1 + d;
            exp_done_cyc = cyc + 2 + d;
          end else if (eng_mode == 2) begin
            fin_at = -1;
            exp_done_cyc = cyc + 2;
          end else begin
            fin_at = -1;
            exp_done_cyc = -1;
          end
        end
        if (eng_mode == 2) f = 3'b111;
        else if (eng_mode == 1 && cyc == fin_at) f[act] = 1'b1;
        if (spur_en) begin
          s = 3'($urandom_range(7, 0));
          s[act] = 1'b0;
          f = f | s;
        end
      end
      bus.h_fin = f[0]; bus.e_fin = f[1]; bus.d_fin = f[2];
    end
  end

  task automatic tick1();
    @(negedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick1();
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick1(); n++; end
    if (done_cnt < target) chk("wait_budget_dones", 64'(done_cnt), 64'(target));
  endtask

  task automatic drive_req(input logic [2:0] m, input logic [IDX_W-1:0] idx, input bit model);
    req_t r;
    bus.H_int = m[0]; bus.E_int = m[1]; bus.D_int = m[2]; bus.index = idx;
    if (model && m != 3'b000) begin
      r.typ = enc(m); r.idx = idx;
      exp_q.push_back(r);
      if ($countones(m) > 1) model_drop = 1;
    end
    tick1();
    bus.H_int = 1'b0; bus.E_int = 1'b0; bus.D_int = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", outs(), 0);
    exp_q.delete();
    model_drop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    vec_t vecs[6];
    int   n, s0, d0, acc;

    vecs[0] = '{3'b001, 11'h2A5, 0, 2'd0, 2, 4, 1'b0};
    vecs[1] = '{3'b010, 11'h001, 2, 2'd1, 2, 6, 1'b0};
    vecs[2] = '{3'b100, 11'h7FF, 1, 2'd2, 2, 5, 1'b0};
    vecs[3] = '{3'b101, 11'h100, 0, 2'd0, 2, 4, 1'b1};
    vecs[4] = '{3'b110, 11'h055, 3, 2'd1, 2, 7, 1'b1};
    vecs[5] = '{3'b111, 11'h000, 0, 2'd0, 2, 4, 1'b1};

    bus.H_int = 1'b0; bus.E_int = 1'b0; bus.D_int = 1'b0; bus.index = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs_initial", outs(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_reset_outputs", outs(), 0);

    // back-to-back E, D, H
    eng_mode = 1; rand_delay = 0; fix_delay = 0;
    s0 = start_cnt; d0 = done_cnt; n = cyc;
    drive_req(3'b010, 11'h001, 1);
    drive_req(3'b100, 11'h002, 1);
    drive_req(3'b001, 11'h003, 1);
    wait_dones(d0 + 3, 100);
    chk("b2b_starts", 64'(start_cnt - s0), 3);
    chk("b2b_last_done_off", 64'(last_done_cyc - n), 12);
    chk("b2b_last_type", last_done_type, 2'd0);
    chk("b2b_err_drop", bus.err_drop, 0);

    // single requests and collisions from the table
    for (int i = 0; i < 6; i++) begin
      fix_delay = vecs[i].delay;
      s0 = start_cnt; d0 = done_cnt; n = cyc;
      drive_req(vecs[i].mask, vecs[i].idx, 1);
      wait_dones(d0 + 1, 50);
      chk("vec_start_count", 64'(start_cnt - s0), 1);
      chk("vec_start_off", 64'(last_start_cyc - n), 64'(vecs[i].start_off));
      chk("vec_start_type", last_start_type, vecs[i].etype);
      chk("vec_start_idx", last_start_idx, vecs[i].idx);
      chk("vec_done_off", 64'(last_done_cyc - n), 64'(vecs[i].done_off));
      chk("vec_err_drop", bus.err_drop, vecs[i].edrop);
      wait_until(n + vecs[i].done_off + 1);
      chk("vec_busy_after", bus.busy, 0);
    end

    do_reset();
    chk("drop_cleared_by_reset", bus.err_drop, 0);

    // overflow: engine silent, six pushes, the sixth must be lost
    eng_mode = 0;
    s0 = start_cnt; d0 = done_cnt; n = cyc;
    for (int i = 0; i < 6; i++) begin
      req_t r;
      if (i == 4) chk("ovf_not_full_yet", bus.fifo_full, 0);
      if (i == 5) begin
        chk("ovf_full_after_5", bus.fifo_full, 1);
        chk("ovf_no_drop_yet", bus.err_drop, 0);
      end
      if (i < 5) begin
        r.typ = 2'(i % 3); r.idx = IDX_W'(16 + i);
        exp_q.push_back(r);
      end
      drive_req(3'(1 << (i % 3)), IDX_W'(16 + i), 0);
    end
    chk("ovf_err_drop", bus.err_drop, 1);
    chk("ovf_still_full", bus.fifo_full, 1);
    eng_mode = 2;
    wait_dones(d0 + 5, 200);
    repeat (6) tick1();
    chk("ovf_serviced", 64'(start_cnt - s0), 5);
    chk("ovf_model_empty", 64'(exp_q.size()), 0);
    chk("ovf_busy_end", bus.busy, 0);
    eng_mode = 0;

`ifdef CRYPTO_DISPATCH_TIMEOUT_EN
    // timeout on E, queued H still dispatched afterwards
    d0 = done_cnt; n = cyc;
    drive_req(3'b010, 11'h0EE, 1);
    drive_req(3'b001, 11'h0AA, 1);
    wait_until(n + 10);
    chk("tmo_no_early_done", bus.E_done, 0);
    chk("tmo_flag_before", bus.err_timeout, 0);
    wait_dones(d0 + 1, 50);
    chk("tmo_done_off", 64'(last_done_cyc - n), 11);
    chk("tmo_done_type", last_done_type, 2'd1);
    eng_mode = 1; fix_delay = 0;
    wait_until(n + 12);
    chk("tmo_flag_set", bus.err_timeout, 1);
    wait_dones(d0 + 2, 50);
    chk("tmo_next_done_off", 64'(last_done_cyc - n), 15);
    chk("tmo_next_type", last_done_type, 2'd0);
    eng_mode = 0;
`endif

    // reset in the middle of WAIT with two requests queued
    n = cyc;
    drive_req(3'b001, 11'h011, 1);
    drive_req(3'b010, 11'h022, 1);
    drive_req(3'b100, 11'h033, 1);
    wait_until(n + 5);
    chk("mid_busy", bus.busy, 1);
    s0 = start_cnt; d0 = done_cnt;
    rst_n = 1'b0;
    #1 chk("mid_reset_outputs", outs(), 0);
    exp_q.delete();
    model_drop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n = cyc;
    wait_until(n + 10);
    chk("mid_no_done", 64'(done_cnt - d0), 0);
    chk("mid_no_start", 64'(start_cnt - s0), 0);
    chk("mid_busy_low", bus.busy, 0);
    eng_mode = 1; fix_delay = 0;
    n = cyc;
    drive_req(3'b001, 11'h3C3, 1);
    wait_dones(d0 + 1, 50);
    chk("mid_new_start_off", 64'(last_start_cyc - n), 2);
    chk("mid_new_idx", last_start_idx, 11'h3C3);
    chk("mid_new_done_off", 64'(last_done_cyc - n), 4);

    // randomized traffic with collisions and stray fins
    eng_mode = 1; rand_delay = 1; spur_en = 1;
    acc = 0; d0 = done_cnt;
    for (int k = 0; k < 400; k++) begin
      if ((acc - (done_cnt - d0)) < DEPTH && $urandom_range(2, 0) == 0) begin
        drive_req(3'($urandom_range(7, 1)), IDX_W'($urandom), 1);
        acc++;
      end else tick1();
    end
    spur_en = 0;
    wait_dones(d0 + acc, 800);
    repeat (3) tick1();
    chk("rand_done_count", 64'(done_cnt - d0), 64'(acc));
    chk("rand_model_empty", 64'(exp_q.size()), 0);
    chk("rand_err_drop", bus.err_drop, 64'(model_drop));
    chk("rand_busy_end", bus.busy, 0);
`ifndef CRYPTO_DISPATCH_TIMEOUT_EN
    chk("no_timeout_flag", bus.err_timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end
endmodule
